// File: rtl/feed_sequencer.sv
// -----------------------------------------------------------------------------
// feed_sequencer
//
// Control stage sitting directly in front of a bank of data_feeder shift
// registers in the systolic MAC datapath.  A run request parallel-loads every
// feeder, then walks a diagonal wavefront of shift enables across the lanes
// (lane i starts i cycles after lane 0).  The MAC accumulate enable is held
// through a drain window so partial sums can finish propagating, and a
// single-cycle done pulse closes the run.
//
// Run timeline (one cycle per line unless noted):
//   IDLE  -> LOAD (1) -> FEED (DEPTH+ROWS-1) -> DRAIN (DRAIN_CYCLES) -> DONE (1)
//
// Parameters:
//   ROWS          number of feeder lanes driven
//   DEPTH         bytes held per feeder (shift enables per lane per run)
//   DRAIN_CYCLES  extra acc_en cycles after the last lane; 0 skips DRAIN
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset, synchronous release
//   start        in   run request, only honoured while idle
//   feeder_load  out  parallel-load strobe to every feeder
//   feeder_en    out  [ROWS] per-lane shift enable
//   lane_valid   out  [ROWS] lane output holds a real operand byte
//   acc_clear    out  clears the MAC accumulators
//   acc_en       out  MAC accumulate enable
//   busy         out  run in progress
//   done         out  one-cycle run-complete pulse
//
// Every output is a flop.  The next state and next count are decoded
// combinationally and the output flops are loaded from that decode, so each
// output is valid in the very cycle its state/count is current.  This keeps
// feeder_load glitch-free for the asynchronous load input it drives.
// -----------------------------------------------------------------------------
module feed_sequencer #(
   parameter int ROWS         = 7,
   parameter int DEPTH        = 7,
   parameter int DRAIN_CYCLES = 6
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   output logic            feeder_load,
   output logic [ROWS-1:0] feeder_en,
   output logic [ROWS-1:0] lane_valid,
   output logic            acc_clear,
   output logic            acc_en,
   output logic            busy,
   output logic            done
);

   // Length of the skewed feed window: lane ROWS-1 finishes DEPTH cycles
   // after it starts, which is ROWS-1 cycles after lane 0 starts.
   localparam int FEED_LEN = DEPTH + ROWS - 1;

   // The single counter is shared by FEED and DRAIN, so it must cover the
   // longer of the two.  Floor at one bit so degenerate sizes still elaborate.
   localparam int CNT_SPAN = (FEED_LEN > DRAIN_CYCLES)
                             ? ((FEED_LEN > 1) ? FEED_LEN : 1)
                             : ((DRAIN_CYCLES > 1) ? DRAIN_CYCLES : 1);
   localparam int CW       = (CNT_SPAN > 1) ? $clog2(CNT_SPAN) : 1;

   localparam logic [CW-1:0] FEED_LAST  = CW'(FEED_LEN - 1);
   localparam logic [CW-1:0] DRAIN_LAST = (DRAIN_CYCLES > 0) ? CW'(DRAIN_CYCLES - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_FEED  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_next;
   logic [ROWS-1:0] w_lane_next;

   logic            r_feeder_load;
   logic [ROWS-1:0] r_feeder_en;
   logic [ROWS-1:0] r_lane_valid;
   logic            r_acc_clear;
   logic            r_acc_en;
   logic            r_busy;
   logic            r_done;

   // ---------------------------------------------------------------------
   // Next-state / next-count decode
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         S_IDLE: begin
            w_cnt_next = '0;
            if (start) begin
               w_state_next = S_LOAD;
            end
         end
         S_LOAD: begin
            w_state_next = S_FEED;
            w_cnt_next   = '0;
         end
         S_FEED: begin
            if (r_cnt == FEED_LAST) begin
               w_cnt_next = '0;
               // With no drain window the run closes straight after feeding.
               if (DRAIN_CYCLES == 0) begin
                  w_state_next = S_DONE;
               end else begin
                  w_state_next = S_DRAIN;
               end
            end else begin
               w_cnt_next = r_cnt + CW'(1);
            end
         end
         S_DRAIN: begin
            if (r_cnt == DRAIN_LAST) begin
               w_state_next = S_DONE;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt + CW'(1);
            end
         end
         S_DONE: begin
            // start is deliberately not looked at here: a held start gives
            // exactly one IDLE cycle between runs.
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
         end
         default: begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Diagonal window per lane: lane gi is active for FEED counts
   // gi .. gi+DEPTH-1.  Decoded from the next count so the registered
   // enable lines up with the cycle that count becomes current.
   // ---------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < ROWS; gi++) begin : g_lane
         assign w_lane_next[gi] = (w_state_next == S_FEED)
                                  && (int'(w_cnt_next) >= gi)
                                  && (int'(w_cnt_next) <= gi + DEPTH - 1);
      end
   endgenerate

   // ---------------------------------------------------------------------
   // State, counter and registered outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_feeder_load <= 1'b0;
         r_feeder_en   <= '0;
         r_lane_valid  <= '0;
         r_acc_clear   <= 1'b0;
         r_acc_en      <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_cnt         <= w_cnt_next;
         r_feeder_load <= (w_state_next == S_LOAD);
         r_acc_clear   <= (w_state_next == S_LOAD);
         r_feeder_en   <= w_lane_next;
         r_lane_valid  <= w_lane_next;
         r_acc_en      <= (w_state_next == S_FEED) || (w_state_next == S_DRAIN);
         r_busy        <= (w_state_next != S_IDLE);
         r_done        <= (w_state_next == S_DONE);
      end
   end

   assign feeder_load = r_feeder_load;
   assign feeder_en   = r_feeder_en;
   assign lane_valid  = r_lane_valid;
   assign acc_clear   = r_acc_clear;
   assign acc_en      = r_acc_en;
   assign busy        = r_busy;
   assign done        = r_done;

endmodule

// File: doc/feed_sequencer.md
Name: feed_sequencer

Overview:
- Control stage directly upstream of the bank of data_feeder shift registers in the systolic MAC datapath.
- On a start request it:
  - loads all feeders in parallel;
  - issues diagonally skewed shift enables, so feeder lane i starts presenting bytes i cycles after lane 0;
  - holds the array's accumulate enable through a drain window;
  - pulses done.
- One instance drives ROWS feeders; row-side and column-side feeder banks each get their own instance, or share one.

Parameters:
- ROWS, 7, number of feeder lanes driven (one feeder_en/lane_valid bit per lane).
- DEPTH, 7, bytes held per feeder (shift enables per lane per run).
- DRAIN_CYCLES, 6, cycles acc_en stays high after the last lane finishes, for partial sums to propagate. 0 is legal and skips DRAIN.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  run request; sampled only in IDLE.
- feeder_load  output  1  parallel-load strobe to every feeder's load/reset input.
- feeder_en  output  ROWS  per-lane shift enable to feeder i.
- lane_valid  output  ROWS  lane i's feeder output holds a real operand byte this cycle.
- acc_clear  output  1  clears MAC accumulators.
- acc_en  output  1  MAC array accumulate enable.
- busy  output  1  run in progress.
- done  output  1  single-cycle run-complete pulse.

Behaviour:
- All outputs come straight from flops, never combinational decode. feeder_load drives an asynchronous input downstream and must be glitch-free.
- Outputs are valid in the same cycle the corresponding state/count is current (next-state values are registered).
- Reset (reset_n low, asynchronous):
  - state goes to IDLE; counter is cleared;
  - every output goes to 0 immediately;
  - a run in progress is abandoned.
  - Release is synchronous to the first subsequent clk edge.
- States: IDLE -> LOAD -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE:
  - all outputs 0.
  - start=1 at an edge moves to LOAD.
- LOAD (1 cycle):
  - feeder_load=1, acc_clear=1, busy=1; all other outputs 0.
  - Next edge moves to FEED with counter c=0.
- FEED (DEPTH+ROWS-1 cycles, c = 0 .. DEPTH+ROWS-2):
  - busy=1, acc_en=1.
  - feeder_en[i]=1 and lane_valid[i]=1 exactly when i <= c <= i+DEPTH-1.
  - Byte k of lane i is on that feeder's output during FEED cycle c=i+k. Zeros shifted into the feeder pad lanes outside their window.
  - On c = DEPTH+ROWS-2: go to DRAIN with c=0, or straight to DONE if DRAIN_CYCLES=0.
- DRAIN (DRAIN_CYCLES cycles):
  - busy=1, acc_en=1; feeder_en=0, lane_valid=0.
  - After the last drain cycle, go to DONE.
- DONE (1 cycle):
  - done=1, busy=1; other outputs 0.
  - Next edge returns to IDLE.
- start handling:
  - start high in any state other than IDLE is ignored; it is not queued.
  - start held high continuously yields back-to-back runs with exactly one IDLE cycle between DONE and the next LOAD.
- Counter width is clog2(max(DEPTH+ROWS-1, DRAIN_CYCLES, 1)) bits. The counter never wraps within a state.
- Per-run totals:
  - each feeder_en[i] is high exactly DEPTH cycles;
  - the sum of feeder_en bits over the run is ROWS*DEPTH;
  - acc_en is high DEPTH+ROWS-1+DRAIN_CYCLES cycles.
- Degenerate parameters:
  - ROWS=1 gives FEED = DEPTH cycles with no skew.
  - DEPTH=1 gives a single-cycle diagonal pulse per lane.

Test Plan:
- Defaults, reset then start pulse for 1 cycle:
  - feeder_load and acc_clear high 1 cycle;
  - FEED lasts 13 cycles: feeder_en[0] high FEED cycles 0-6, feeder_en[6] high cycles 6-12;
  - DRAIN 6 cycles;
  - done pulses on the 21st cycle after LOAD's first cycle; busy is high for 21 cycles total.
- Defaults, feeders loaded with bytes 0x01..0x07 per lane: lane 3's output sampled when lane_valid[3]=1 reads 0x01..0x07 on FEED cycles 3..9; the output is 0x00 after.
- start re-pulsed during FEED and during DONE: ignored; exactly one done pulse; the next run begins only after IDLE.
- start held high for 3 runs: done pulses spaced exactly 22 cycles apart; 3×49 feeder_en lane-cycles counted.
- reset_n dropped mid-FEED at c=5 (asynchronous, between edges): all outputs go to 0 before the next edge; after release the block stays IDLE until a new start.
- ROWS=4, DEPTH=3, DRAIN_CYCLES=0: FEED 6 cycles then DONE directly; acc_en high 6 cycles; feeder_en[3] high on c=3..5.
